tcam_match_sequencer: RTL

Parametrised, registered successor to the TCAM combinational priority encoders. It captures an N-entry TCAM match-line vector through a valid/ready handshake. It then emits the matching entry indices one per beat, highest index first, either the top match only or every match. It sits between the TCAM match array and the result/lookup consumer and supplies back-pressure to both.

---
 rtl/tcam_match_sequencer_pkg.sv | 24 ++
 rtl/tcam_match_sequencer_pr_encoder.sv | 68 ++++++
 rtl/tcam_match_sequencer.sv | 80 ++++++++
 3 files changed

// File: rtl/tcam_match_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tcam_match_sequencer_pkg
//  Brief    : Shared state encoding and width helper for the TCAM sequencer.
//  Revision : 1.0
// ============================================================================
package tcam_match_sequencer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcam_match_sequencer_pr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : pr_encoder_param
//  Brief    : Combinational N -> W priority encoder (highest index wins),
//             built as a tree of 4-way nodes.
//  Revision : 1.0
// ============================================================================
module pr_encoder_param
    import tcam_match_sequencer_pkg::*;
#(
    parameter  int N = 16,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);

    // The leaf vector is padded up to a power of four so every node has
    // exactly four children; padded bits never win because they are zero.
    localparam int L  = (W + 1) / 2;
    localparam int IW = 2 * L;
    localparam int NP = 1 << IW;

    logic [NP-1:0] w_leaf;

    for (genvar gi = 0; gi < NP; gi++) begin : g_pad
        if (gi < N) begin : g_real
            assign w_leaf[gi] = i_vec[gi];
        end else begin : g_zero
            assign w_leaf[gi] = 1'b0;
        end
    end

    for (genvar gl = 1; gl <= L; gl++) begin : g_lvl
        localparam int NN = NP >> (2 * gl);
        logic [NN-1:0]    w_v;
        logic [NN*IW-1:0] w_ix;

        for (genvar gj = 0; gj < NN; gj++) begin : g_node
            logic [3:0]      w_cv;
            logic [4*IW-1:0] w_cix;
            logic [1:0]      w_sel;

            if (gl == 1) begin : g_leafin
                assign w_cv  = w_leaf[4*gj +: 4];
                assign w_cix = '0;
            end else begin : g_nodein
                assign w_cv  = g_lvl[gl-1].w_v[4*gj +: 4];
                assign w_cix = g_lvl[gl-1].w_ix[4*gj*IW +: 4*IW];
            end

            assign w_sel = w_cv[3] ? 2'd3 :
                           w_cv[2] ? 2'd2 :
                           w_cv[1] ? 2'd1 : 2'd0;

            // Child code supplies the low bits, this node's pick the next two.
            assign w_v[gj]            = |w_cv;
            assign w_ix[gj*IW +: IW]  = w_cix[w_sel*IW +: IW]
                                      | (IW'(w_sel) << (2 * (gl - 1)));
        end
    end

    assign o_valid = g_lvl[L].w_v[0];
    assign o_idx   = g_lvl[L].w_ix[W-1:0];

endmodule
`default_nettype wire

// File: rtl/tcam_match_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tcam_match_sequencer
//  Brief    : Captures a TCAM match vector and emits matching indices one per
//             beat, highest first (top match only or every match).
//  Revision : 1.0
// ============================================================================
module tcam_match_sequencer
    import tcam_match_sequencer_pkg::*;
#(
    parameter  int N = 16,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_match,
    input  logic         in_mode_all,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_index,
    output logic         out_none,
    output logic         out_last
);

    state_t       r_state;
    logic [N-1:0] r_pend;
    logic         r_mode;
    logic         r_empty;

    logic [W-1:0] w_idx;
    logic         w_hit;
    logic [N-1:0] w_top;
    logic [N-1:0] w_rest;
    logic         w_scan;
    logic         w_last;
    logic         w_accept;

    pr_encoder_param #(.N(N)) u_enc (
        .i_vec   (r_pend),
        .o_idx   (w_idx),
        .o_valid (w_hit)
    );

    // One-hot of the current winner; clearing it exposes the next match.
    assign w_top    = {{(N-1){1'b0}}, 1'b1} << w_idx;
    assign w_rest   = r_pend & ~w_top;

    assign w_scan   = (r_state == ST_SCAN);
    assign w_last   = w_scan && (r_empty || !r_mode || (w_rest == '0));

    assign out_valid = w_scan;
    assign out_index = (w_scan && w_hit) ? w_idx : '0;
    assign out_none  = w_scan && r_empty;
    assign out_last  = w_last;

    // Accepting during the final beat keeps the pipe full with no bubble.
    assign in_ready  = !w_scan || (out_ready && w_last);
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_mode  <= 1'b0;
            r_empty <= 1'b0;
        end else if (w_accept) begin
            r_state <= ST_SCAN;
            r_pend  <= in_match;
            r_mode  <= in_mode_all;
            r_empty <= (in_match == '0);
        end else if (w_scan && out_ready) begin
            r_pend <= w_rest;
            if (w_last) r_state <= ST_IDLE;
        end
    end

endmodule
`default_nettype wire
